axi_slv_mem: RTL and testbench

- AXI3 slave responder backed by an internal word-addressed RAM; the far end of the DDR bandwidth-test master.
- Lets the read/write master engines be exercised in simulation and on-fabric loopback without the PS DDR.
- Independent read and write channel FSMs, one outstanding transaction per direction, INCR bursts only.
- Free-running beat counters and a sticky error flag for bandwidth and integrity checks.

---
 rtl/axi_slv_mem.sv | 272 +++++++++++++++++++++++++++
 tb/tb_axi_slv_mem.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slv_mem.sv
// AXI3 slave backed by a word-addressed RAM: independent read/write FSMs, INCR bursts only,
// one outstanding transaction per direction, free-running beat counters and a sticky error flag.
module axi_slv_mem #(
  parameter int ID_WIDTH       = 6,
  parameter int DATA_WIDTH     = 64,
  parameter int B_BURST_LENGTH = 4,
  parameter int MEM_AW         = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [31:0]               s_axi_awaddr,
  input  logic [B_BURST_LENGTH-1:0] s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [ID_WIDTH-1:0]       s_axi_wid,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [31:0]               s_axi_araddr,
  input  logic [B_BURST_LENGTH-1:0] s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [31:0]               wr_beats,
  output logic [31:0]               rd_beats,
  output logic                      err
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int L      = $clog2(STRB_W);
  localparam int LW     = B_BURST_LENGTH;
  localparam int CW     = B_BURST_LENGTH + 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
    bad_req = (burst != 2'b01) || (size != 3'(L));
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];
  logic [DATA_WIDTH-1:0] ram_q;

  w_state_t            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d;
  logic [MEM_AW-1:0]   widx_q, widx_d;
  logic [LW-1:0]       wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic                werr_q, werr_d;
  logic                awready_q, wready_q, bvalid_q;
  logic                aw_hs_s, w_hs_s, mem_we_s;

  r_state_t            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [MEM_AW-1:0]   ridx_q, ridx_d, rd_idx_s;
  logic [LW-1:0]       rlen_q, rlen_d;
  logic [CW-1:0]       ricnt_q, ricnt_d;
  logic                rerr_q, rerr_d, arready_q;
  logic                pipe_vld_q, pipe_last_q;
  logic [DATA_WIDTH-1:0] ent_data_q [2];
  logic                ent_last_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          rcnt_q, rcnt_d;
  logic [2:0]          occ_s;
  logic                ar_hs_s, r_pop_s, rd_issue_s, rd_last_s;
  logic [31:0]         wr_beats_q, rd_beats_q;
  logic                err_q, err_d;
  logic                unused_s;

  assign unused_s = ^{s_axi_wid, s_axi_awaddr[31:MEM_AW+L], s_axi_awaddr[L-1:0],
                      s_axi_araddr[31:MEM_AW+L], s_axi_araddr[L-1:0]};

  // Write channel next-state: address latch, counted data beats, response hold.
  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    mem_we_s  = 1'b0;
    aw_hs_s   = s_axi_awvalid && awready_q;
    w_hs_s    = s_axi_wvalid && wready_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          wid_d     = s_axi_awid;
          widx_d    = s_axi_awaddr[MEM_AW+L-1:L];
          wlen_d    = s_axi_awlen;
          wcnt_d    = {LW{1'b0}};
          werr_d    = bad_req(s_axi_awsize, s_axi_awburst);
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s) begin
          mem_we_s  = !werr_q && !rst;
          widx_d    = widx_q + MEM_AW'(1);
          wcnt_d    = wcnt_q + LW'(1);
          werr_d    = werr_q || (s_axi_wlast != (wcnt_q == wlen_q));
          w_state_d = (wcnt_q == wlen_q) ? W_RESP : W_DATA;
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: issue RAM reads only while the skid buffer plus in-flight read has room.
  always_comb begin
    r_state_d  = r_state_q;
    rid_d      = rid_q;
    ridx_d     = ridx_q;
    rlen_d     = rlen_q;
    ricnt_d    = ricnt_q;
    rerr_d     = rerr_q;
    rd_issue_s = 1'b0;
    rd_last_s  = 1'b0;
    rd_idx_s   = ridx_q;
    ar_hs_s    = s_axi_arvalid && arready_q;
    r_pop_s    = (rcnt_q != 2'd0) && s_axi_rready;
    occ_s      = {1'b0, rcnt_q} + {2'b00, pipe_vld_q} - {2'b00, r_pop_s};
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rid_d      = s_axi_arid;
          rlen_d     = s_axi_arlen;
          rerr_d     = bad_req(s_axi_arsize, s_axi_arburst);
          rd_issue_s = 1'b1;
          rd_idx_s   = s_axi_araddr[MEM_AW+L-1:L];
          rd_last_s  = (s_axi_arlen == {LW{1'b0}});
          ridx_d     = s_axi_araddr[MEM_AW+L-1:L] + MEM_AW'(1);
          ricnt_d    = CW'(1);
          r_state_d  = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if ((ricnt_q <= {1'b0, rlen_q}) && (occ_s < 3'd2)) begin
          rd_issue_s = 1'b1;
          rd_last_s  = (ricnt_q == {1'b0, rlen_q});
          ridx_d     = ridx_q + MEM_AW'(1);
          ricnt_d    = ricnt_q + CW'(1);
        end else begin
          rd_issue_s = 1'b0;
        end
        if (r_pop_s && ent_last_q[rd_ptr_q]) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    rcnt_d = rcnt_q + {1'b0, pipe_vld_q} - {1'b0, r_pop_s};
    err_d  = err_q || ((w_state_d == W_RESP) && werr_d) || ((rcnt_d != 2'd0) && rerr_q);
  end

  // RAM: byte-enabled write port and synchronous read port (read returns pre-write data).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem_q[widx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
    if (rd_issue_s) ram_q <= mem_q[rd_idx_s];
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      wid_q      <= {ID_WIDTH{1'b0}};
      widx_q     <= {MEM_AW{1'b0}};
      wlen_q     <= {LW{1'b0}};
      wcnt_q     <= {LW{1'b0}};
      werr_q     <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      r_state_q  <= R_IDLE;
      rid_q      <= {ID_WIDTH{1'b0}};
      ridx_q     <= {MEM_AW{1'b0}};
      rlen_q     <= {LW{1'b0}};
      ricnt_q    <= {CW{1'b0}};
      rerr_q     <= 1'b0;
      arready_q  <= 1'b0;
      pipe_vld_q <= 1'b0;
      pipe_last_q <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        ent_data_q[e] <= {DATA_WIDTH{1'b0}};
        ent_last_q[e] <= 1'b0;
      end
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rcnt_q     <= 2'd0;
      wr_beats_q <= 32'd0;
      rd_beats_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      wid_q      <= wid_d;
      widx_q     <= widx_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      awready_q  <= (w_state_d == W_IDLE);
      wready_q   <= (w_state_d == W_DATA);
      bvalid_q   <= (w_state_d == W_RESP);
      r_state_q  <= r_state_d;
      rid_q      <= rid_d;
      ridx_q     <= ridx_d;
      rlen_q     <= rlen_d;
      ricnt_q    <= ricnt_d;
      rerr_q     <= rerr_d;
      arready_q  <= (r_state_d == R_IDLE);
      pipe_vld_q <= rd_issue_s;
      pipe_last_q <= rd_last_s;
      if (pipe_vld_q) begin
        ent_data_q[wr_ptr_q] <= rerr_q ? {DATA_WIDTH{1'b0}} : ram_q;
        ent_last_q[wr_ptr_q] <= pipe_last_q;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (r_pop_s) rd_ptr_q <= ~rd_ptr_q;
      rcnt_q     <= rcnt_d;
      wr_beats_q <= wr_beats_q + (w_hs_s ? 32'd1 : 32'd0);
      rd_beats_q <= rd_beats_q + (r_pop_s ? 32'd1 : 32'd0);
      err_q      <= err_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = wid_q;
  assign s_axi_bresp   = {werr_q, 1'b0};
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = (rcnt_q != 2'd0);
  assign s_axi_rdata   = ent_data_q[rd_ptr_q];
  assign s_axi_rlast   = ent_last_q[rd_ptr_q] && (rcnt_q != 2'd0);
  assign s_axi_rresp   = {rerr_q, 1'b0};
  assign s_axi_rid     = rid_q;
  assign wr_beats      = wr_beats_q;
  assign rd_beats      = rd_beats_q;
  assign err           = err_q;
endmodule

// File: tb/tb_axi_slv_mem.sv
// Scoreboard bench for axi_slv_mem: tasks push expected B/R responses, a negedge monitor checks them.
module tb_axi_slv_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  s_axi_awid, s_axi_wid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [3:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [31:0] wr_beats, rd_beats;
  logic        err;

  always #5 clk = ~clk;

  axi_slv_mem dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .wr_beats(wr_beats), .rd_beats(rd_beats), .err(err)
  );

  typedef struct packed { logic [5:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [5:0] id; logic [1:0] resp; logic last; logic [63:0] data; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_wr  = 0;
  int          exp_rd  = 0;
  logic [63:0] ref_mem [0:1023];
  bit          rready_toggle = 1'b0;
  bit          stalled = 1'b0;
  logic [63:0] held_data;
  logic [8:0]  held_meta;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit ready_of(input int ch);
    case (ch)
      0:       return s_axi_awready;
      1:       return s_axi_wready;
      2:       return s_axi_arready;
      default: return 1'b0;
    endcase
  endfunction

  // Waits for the channel ready, completes the handshake edge and returns 1 time unit after it.
  task automatic hs_wait(input int ch, input string name);
    int n = 0;
    @(negedge clk);
    while (!ready_of(ch) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready_of(ch)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got ready=0 expected ready=1 within 500 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input logic [63:0] base,
                             input logic [7:0] strb, input int bad_beat);
    bit bad;
    int idx;
    bad = (burst != 2'b01) || (size != 3'd3) || (bad_beat >= 0);
    idx = int'(addr[12:3]);
    bq.push_back(b_exp_t'{id: id, resp: (bad ? 2'b10 : 2'b00)});
    exp_wr += int'(len) + 1;
    if (!bad) begin
      for (int i = 0; i <= int'(len); i++) begin
        for (int b = 0; b < 8; b++) begin
          if (strb[b]) ref_mem[(idx + i) % 1024][8*b +: 8] = (base + 64'(i)) >> (8*b);
        end
      end
    end
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awburst = burst; s_axi_awsize = size; s_axi_awvalid = 1'b1;
    hs_wait(0, "aw");
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wid   = id;
      s_axi_wdata = base + 64'(i);
      s_axi_wstrb = strb;
      s_axi_wlast = (bad_beat >= 0) ? (i == bad_beat) : (i == int'(len));
      s_axi_wvalid = 1'b1;
      hs_wait(1, "w");
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
  endtask

  task automatic read_burst(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input bit chk_lat);
    bit bad;
    int idx;
    bad = (burst != 2'b01) || (size != 3'd3);
    idx = int'(addr[12:3]);
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back(r_exp_t'{id: id, resp: (bad ? 2'b10 : 2'b00), last: (i == int'(len)),
                            data: (bad ? 64'd0 : ref_mem[(idx + i) % 1024])});
    end
    exp_rd += int'(len) + 1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arburst = burst; s_axi_arsize = size; s_axi_arvalid = 1'b1;
    hs_wait(2, "ar");
    s_axi_arvalid = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      check("r_latency_c1", 64'(s_axi_rvalid), 64'd0);
      @(negedge clk);
      check("r_latency_c2", 64'(s_axi_rvalid), 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain: got %0d B / %0d R pending expected 0", name, bq.size(), rq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every B/R handshake against the scoreboard and R stability while stalled.
  always @(negedge clk) begin
    b_exp_t be;
    r_exp_t re;
    if (stalled && !rst) begin
      check("r_stall_valid", 64'(s_axi_rvalid), 64'd1);
      check("r_stall_data", s_axi_rdata, held_data);
      check("r_stall_meta", 64'({s_axi_rid, s_axi_rresp, s_axi_rlast}), 64'(held_meta));
    end
    stalled = 1'b0;
    if (!rst && s_axi_rvalid) begin
      if (s_axi_rready) begin
        if (rq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL r_unexpected: got beat %h expected none", s_axi_rdata);
        end else begin
          re = rq.pop_front();
          check("r_data", s_axi_rdata, re.data);
          check("r_id_resp_last", 64'({s_axi_rid, s_axi_rresp, s_axi_rlast}),
                64'({re.id, re.resp, re.last}));
          if (re.resp == 2'b10) check("r_err_sticky", 64'(err), 64'd1);
        end
      end else begin
        stalled   = 1'b1;
        held_data = s_axi_rdata;
        held_meta = {s_axi_rid, s_axi_rresp, s_axi_rlast};
      end
    end
    if (!rst && s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected: got bid %h expected none", s_axi_bid);
      end else begin
        be = bq.pop_front();
        check("b_id_resp", 64'({s_axi_bid, s_axi_bresp}), 64'({be.id, be.resp}));
        if (be.resp == 2'b10) check("b_err_sticky", 64'(err), 64'd1);
      end
    end
  end

  initial begin
    s_axi_rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_axi_rready = rready_toggle ? ~s_axi_rready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_awid = 6'd0; s_axi_awaddr = 32'd0; s_axi_awlen = 4'd0; s_axi_awsize = 3'd3;
    s_axi_awburst = 2'b01; s_axi_wid = 6'd0; s_axi_wdata = 64'd0; s_axi_wstrb = 8'd0;
    s_axi_wlast = 1'b0; s_axi_arid = 6'd0; s_axi_araddr = 32'd0; s_axi_arlen = 4'd0;
    s_axi_arsize = 3'd3; s_axi_arburst = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
    check("rst_valids", 64'({s_axi_bvalid, s_axi_rvalid, s_axi_rlast}), 64'd0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    check("rst_ids_resps", 64'({s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}), 64'd0);
    check("rst_counters", {wr_beats, rd_beats}, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Basic 8-beat write then read with first-beat latency check.
    write_burst(6'd1, 32'h100, 4'd7, 2'b01, 3'd3, 64'd0, 8'hFF, -1);
    wait_drain("t1_wr");
    read_burst(6'd2, 32'h100, 4'd7, 2'b01, 3'd3, 1'b1);
    wait_drain("t1_rd");
    check("t1_wr_beats", 64'(wr_beats), 64'd8);
    check("t1_rd_beats", 64'(rd_beats), 64'd8);
    check("t1_err", 64'(err), 64'd0);

    // 16-beat read under rready back-pressure.
    write_burst(6'd3, 32'h200, 4'd15, 2'b01, 3'd3, 64'h1000, 8'hFF, -1);
    wait_drain("t2_wr");
    rready_toggle = 1'b1;
    read_burst(6'd4, 32'h200, 4'd15, 2'b01, 3'd3, 1'b0);
    wait_drain("t2_rd");
    rready_toggle = 1'b0;
    check("t2_rd_beats", 64'(rd_beats), 64'(exp_rd));

    // Partial byte strobes over an all-ones word.
    write_burst(6'd6, 32'h400, 4'd0, 2'b01, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, -1);
    write_burst(6'd6, 32'h400, 4'd0, 2'b01, 3'd3, 64'd0, 8'h0F, -1);
    wait_drain("t3_wr");
    read_burst(6'd7, 32'h400, 4'd0, 2'b01, 3'd3, 1'b0);
    wait_drain("t3_rd");
    check("t3_err", 64'(err), 64'd0);

    // FIXED burst: beats accepted, RAM untouched, SLVERR, sticky err.
    write_burst(6'd8, 32'h500, 4'd3, 2'b01, 3'd3, 64'hA0, 8'hFF, -1);
    write_burst(6'd9, 32'h500, 4'd3, 2'b00, 3'd3, 64'hDEAD_0000, 8'hFF, -1);
    wait_drain("t4_wr");
    check("t4_err_set", 64'(err), 64'd1);
    read_burst(6'd10, 32'h500, 4'd3, 2'b01, 3'd3, 1'b0);
    wait_drain("t4_rd");
    check("t4_err_stays", 64'(err), 64'd1);
    check("t4_wr_beats", 64'(wr_beats), 64'(exp_wr));

    // Address wrap from word 1022 through word 1.
    write_burst(6'd11, 32'h1FF0, 4'd3, 2'b01, 3'd3, 64'h5000, 8'hFF, -1);
    wait_drain("t5_wr");
    read_burst(6'd12, 32'h1FF0, 4'd3, 2'b01, 3'd3, 1'b0);
    read_burst(6'd13, 32'h0000, 4'd1, 2'b01, 3'd3, 1'b0);
    wait_drain("t5_rd");

    // Misplaced wlast and bad arsize both give SLVERR; the read returns zeros.
    write_burst(6'd14, 32'h960, 4'd1, 2'b01, 3'd3, 64'h77, 8'hFF, 0);
    read_burst(6'd15, 32'h100, 4'd1, 2'b01, 3'd2, 1'b0);
    wait_drain("t6");

    // Concurrent write and read with distinct IDs.
    fork
      write_burst(6'd5, 32'h800, 4'd15, 2'b01, 3'd3, 64'h7000, 8'hFF, -1);
      read_burst(6'd9, 32'h200, 4'd15, 2'b01, 3'd3, 1'b0);
    join
    wait_drain("t7");
    check("t7_wr_beats", 64'(wr_beats), 64'(exp_wr));
    check("t7_rd_beats", 64'(rd_beats), 64'(exp_rd));

    // Reset in the middle of a read burst.
    read_burst(6'd4, 32'h200, 4'd15, 2'b01, 3'd3, 1'b0);
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t8_rvalid_after_rst", 64'(s_axi_rvalid), 64'd0);
    check("t8_arready_in_rst", 64'(s_axi_arready), 64'd0);
    check("t8_counters_cleared", {wr_beats, rd_beats}, 64'd0);
    check("t8_err_cleared", 64'(err), 64'd0);
    rq.delete();
    exp_wr = 0;
    exp_rd = 0;
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t8_arready_after_rst", 64'(s_axi_arready), 64'd1);
    check("t8_awready_after_rst", 64'(s_axi_awready), 64'd1);
    @(posedge clk); #1;
    read_burst(6'd16, 32'h100, 4'd7, 2'b01, 3'd3, 1'b1);
    wait_drain("t8_rd");
    check("t8_rd_beats", 64'(rd_beats), 64'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
